// File: rtl/mul_acc_pkg.sv
// Shared types and helpers for the multiply-accumulate frame block.
// Optional feature macro used by this slice: MUL_ACC_SAT_EN (saturating sum).
package mul_acc_pkg;

  // state | meaning
  // ACCUM | accepting product beats into the running sum
  // HOLD  | frame result held on the down side until taken
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Width of a counter that must represent 0..max_len inclusive.
  function automatic int count_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/mul_acc_if.sv
// Upstream product stream and downstream frame-result handshake bundle.
// Optional feature macro used by this slice: MUL_ACC_SAT_EN (no effect here).
interface mul_acc_if #(
  parameter int n       = 8,
  parameter int acc_w   = 2*n+4,
  parameter int max_len = 16
);
  import mul_acc_pkg::*;

  localparam int CW = count_width(max_len);

  logic             up_valid;
  logic             up_ready;
  logic [2*n-1:0]   up_prod;
  logic             up_signed;
  logic             up_last;
  logic             down_valid;
  logic             down_ready;
  logic [acc_w-1:0] down_acc;
  logic [CW-1:0]    down_count;
  logic             down_ovf;

  modport slave (
    input  up_valid, up_prod, up_signed, up_last, down_ready,
    output up_ready, down_valid, down_acc, down_count, down_ovf
  );

  modport master (
    output up_valid, up_prod, up_signed, up_last, down_ready,
    input  up_ready, down_valid, down_acc, down_count, down_ovf
  );

endinterface

// File: rtl/mul_acc_add.sv
// Combinational extend/add/overflow stage for one product beat.
// Macro MUL_ACC_SAT_EN: when defined, overflowing sums clamp to the frame-mode
// limit instead of wrapping.
module mul_acc_add #(
  parameter int n     = 8,
  parameter int acc_w = 2*n+4
) (
  input  logic [acc_w-1:0] i_acc,
  input  logic [2*n-1:0]   i_prod,
  input  logic             i_signed,
  input  logic             i_mode,
  output logic [acc_w-1:0] o_sum,
  output logic             o_ovf
);

  // Two guard bits hold any acc +/- beat result exactly, in either mode.
  localparam int XW = acc_w + 2;

  logic [XW-1:0] w_acc_x;
  logic [XW-1:0] w_prod_x;
  logic [XW-1:0] w_full;
  logic [2:0]    w_top_s;

  // The accumulator is read in frame mode; the beat is extended by its own flag.
  assign w_acc_x  = i_mode   ? {{2{i_acc[acc_w-1]}}, i_acc} : {2'b00, i_acc};
  assign w_prod_x = i_signed ? {{(XW-2*n){i_prod[2*n-1]}}, i_prod}
                             : {{(XW-2*n){1'b0}}, i_prod};
  assign w_full   = w_acc_x + w_prod_x;
  assign w_top_s  = w_full[XW-1:acc_w-1];

  assign o_ovf = i_mode ? !((w_top_s == 3'b000) || (w_top_s == 3'b111))
                        : (w_full[XW-1:acc_w] != 2'b00);

`ifdef MUL_ACC_SAT_EN
  // Clamp toward the side the exact sum left the frame-mode range on.
  always_comb begin
    o_sum = w_full[acc_w-1:0];
    if (o_ovf) begin
      if (i_mode) begin
        o_sum = w_full[XW-1] ? {1'b1, {(acc_w-1){1'b0}}} : {1'b0, {(acc_w-1){1'b1}}};
      end else begin
        o_sum = w_full[XW-1] ? {acc_w{1'b0}} : {acc_w{1'b1}};
      end
    end
  end
`else
  assign o_sum = w_full[acc_w-1:0];
`endif

endmodule

// File: rtl/mul_acc.sv
// Frame accumulator: sums product beats, hands the frame result downstream.
// Macro MUL_ACC_SAT_EN: selects saturating instead of wrapping accumulation.
module mul_acc
  import mul_acc_pkg::*;
#(
  parameter int n       = 8,
  parameter int acc_w   = 2*n+4,
  parameter int max_len = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  mul_acc_if.slave   bus
);

  localparam int CW = count_width(max_len);

  if (acc_w < 2*n+1) begin : g_acc_w_chk
    $error("mul_acc: acc_w must be at least 2*n+1");
  end
  if (max_len < 1) begin : g_max_len_chk
    $error("mul_acc: max_len must be at least 1");
  end

  state_t           r_state;
  logic             r_up_ready;
  logic             r_down_valid;
  logic             r_mode;
  logic             r_ovf;
  logic [acc_w-1:0] r_acc;
  logic [CW-1:0]    r_count;

  logic             w_accept;
  logic             w_mode;
  logic [CW-1:0]    w_count_nxt;
  logic             w_done;
  logic [acc_w-1:0] w_sum;
  logic             w_ovf;

  assign w_accept    = bus.up_valid && r_up_ready;
  // The first beat of a frame fixes the mode used to judge overflow.
  assign w_mode      = (r_count == '0) ? bus.up_signed : r_mode;
  assign w_count_nxt = r_count + CW'(1);
  assign w_done      = bus.up_last || (w_count_nxt == CW'(max_len));

  mul_acc_add #(.n(n), .acc_w(acc_w)) u_add (
    .i_acc    (r_acc),
    .i_prod   (bus.up_prod),
    .i_signed (bus.up_signed),
    .i_mode   (w_mode),
    .o_sum    (w_sum),
    .o_ovf    (w_ovf)
  );

  // Frame FSM with registered handshake outputs; up_ready rises one clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ACCUM;
      r_up_ready   <= 1'b0;
      r_down_valid <= 1'b0;
      r_mode       <= 1'b0;
      r_ovf        <= 1'b0;
      r_acc        <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          r_up_ready <= 1'b1;
          if (w_accept) begin
            r_acc   <= w_sum;
            r_count <= w_count_nxt;
            r_ovf   <= r_ovf | w_ovf;
            r_mode  <= w_mode;
            if (w_done) begin
              r_state      <= HOLD;
              r_up_ready   <= 1'b0;
              r_down_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.down_ready) begin
            r_state      <= ACCUM;
            r_up_ready   <= 1'b1;
            r_down_valid <= 1'b0;
            r_acc        <= '0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
            r_mode       <= 1'b0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign bus.up_ready   = r_up_ready;
  assign bus.down_valid = r_down_valid;
  assign bus.down_acc   = r_acc;
  assign bus.down_count = r_count;
  assign bus.down_ovf   = r_ovf;

endmodule

// File: tb/tb_mul_acc.sv
// Scoreboard bench for mul_acc (n=8, acc_w=17, max_len=4).
// Honours MUL_ACC_SAT_EN in its reference model.
module tb_mul_acc;

  localparam int N     = 8;
  localparam int ACC_W = 17;
  localparam int MAXL  = 4;
  localparam longint MASK = (longint'(1) << ACC_W) - 1;

  typedef struct {
    logic [ACC_W-1:0] acc;
    int               cnt;
    bit               ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mul_acc_if #(.n(N), .acc_w(ACC_W), .max_len(MAXL)) bus ();

  mul_acc #(.n(N), .acc_w(ACC_W), .max_len(MAXL)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  exp_t   sb_q[$];

  longint m_sum;
  int     m_cnt;
  bit     m_mode;
  bit     m_ovf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_sum  = 0;
    m_cnt  = 0;
    m_mode = 1'b0;
    m_ovf  = 1'b0;
  endtask

  // Reference: exact integer sum, range-checked in the frame's mode.
  task automatic model_beat(input logic [15:0] p, input bit s, input bit last, output bit pushed);
    longint v, t, lo, hi;
    exp_t e;
    v = s ? longint'($signed(p)) : longint'(p);
    if (m_cnt == 0) m_mode = s;
    t = m_sum + v;
    if (m_mode) begin
      lo = -(longint'(1) << (ACC_W-1));
      hi = (longint'(1) << (ACC_W-1)) - 1;
    end else begin
      lo = 0;
      hi = MASK;
    end
    if (t < lo || t > hi) begin
      m_ovf = 1'b1;
`ifdef MUL_ACC_SAT_EN
      t = (t < lo) ? lo : hi;
`else
      t = m_mode ? (((t - lo) & MASK) + lo) : (t & MASK);
`endif
    end
    m_sum = t;
    m_cnt++;
    pushed = 1'b0;
    if (last || m_cnt == MAXL) begin
      e.acc = ACC_W'(m_sum & MASK);
      e.cnt = m_cnt;
      e.ovf = m_ovf;
      sb_q.push_back(e);
      model_clear();
      pushed = 1'b1;
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send_beat(input logic [15:0] p, input bit s, input bit last);
    int k;
    bit pushed;
    bus.up_valid  = 1'b1;
    bus.up_prod   = p;
    bus.up_signed = s;
    bus.up_last   = last;
    k = 0;
    forever begin
      @(negedge clk);
      if (bus.up_ready) break;
      k++;
      if (k > 50) begin
        chk("up_ready_timeout", 64'd0, 64'd1);
        bus.up_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    bus.up_valid = 1'b0;
    bus.up_prod  = 16'hxxxx;
    bus.up_last  = 1'bx;
    model_beat(p, s, last, pushed);
    if (pushed) chk("latency_dv", 64'(bus.down_valid), 64'd1);
  endtask

  task automatic take_result(input int hold);
    int k;
    k = 0;
    while (!bus.down_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.down_valid) begin
      chk("down_valid_timeout", 64'd0, 64'd1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (sb_q.size() > 0) chk("hold_acc", 64'(bus.down_acc), 64'(sb_q[0].acc));
      chk("hold_up_ready", 64'(bus.up_ready), 64'd0);
      chk("hold_dv", 64'(bus.down_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.down_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.down_ready = 1'b0;
    chk("post_up_ready", 64'(bus.up_ready), 64'd1);
    chk("post_dv", 64'(bus.down_valid), 64'd0);
    chk("post_acc", 64'(bus.down_acc), 64'd0);
    chk("post_cnt", 64'(bus.down_count), 64'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_dv", 64'(bus.down_valid), 64'd0);
    chk("rst_up_ready", 64'(bus.up_ready), 64'd0);
    chk("rst_acc", 64'(bus.down_acc), 64'd0);
    chk("rst_cnt", 64'(bus.down_count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    chk("rst_rel_up_ready", 64'(bus.up_ready), 64'd1);
  endtask

  // Pop and compare the expected frame at each down handshake.
  always @(negedge clk) begin
    if (rst_n && bus.down_valid && bus.down_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("res_acc", 64'(bus.down_acc), 64'(e.acc));
        chk("res_cnt", 64'(bus.down_count), 64'(e.cnt));
        chk("res_ovf", 64'(bus.down_ovf), 64'(e.ovf));
      end
    end
  end

  initial begin
    int len;
    bus.up_valid   = 1'b0;
    bus.up_prod    = '0;
    bus.up_signed  = 1'b0;
    bus.up_last    = 1'b0;
    bus.down_ready = 1'b0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_up_ready", 64'(bus.up_ready), 64'd0);
    chk("reset_dv", 64'(bus.down_valid), 64'd0);
    chk("reset_acc", 64'(bus.down_acc), 64'd0);
    chk("reset_cnt", 64'(bus.down_count), 64'd0);
    chk("reset_ovf", 64'(bus.down_ovf), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_up_ready_low", 64'(bus.up_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rel_up_ready_high", 64'(bus.up_ready), 64'd1);

    // Unsigned frame with explicit last.
    send_beat(16'h0010, 1'b0, 1'b0);
    send_beat(16'h0020, 1'b0, 1'b0);
    send_beat(16'h0030, 1'b0, 1'b1);
    take_result(0);

    // Signed frame landing negative.
    send_beat(16'hFFF0, 1'b1, 1'b0);
    send_beat(16'h0008, 1'b1, 1'b1);
    take_result(0);

    // Length-limited frame; extra valid must wait while held, then a long hold.
    for (int i = 0; i < 4; i++) send_beat(16'h0001, 1'b0, 1'b0);
    bus.up_valid = 1'b1;
    bus.up_prod  = 16'h0055;
    repeat (3) begin
      @(negedge clk);
      chk("full_up_ready", 64'(bus.up_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.up_valid = 1'b0;
    take_result(5);

    // Unsigned overflow.
    send_beat(16'hFFFF, 1'b0, 1'b0);
    send_beat(16'hFFFF, 1'b0, 1'b0);
    send_beat(16'hFFFF, 1'b0, 1'b1);
    take_result(1);

    // Signed overflow on the negative side.
    for (int i = 0; i < 4; i++) send_beat(16'h8000, 1'b1, 1'b0);
    take_result(0);

    // Random frames with mixed per-beat extension.
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, MAXL);
      for (int i = 0; i < len; i++) begin
        send_beat(16'($urandom), 1'($urandom_range(0, 1)),
                  (i == len-1) ? 1'($urandom_range(0, 1) | (len < MAXL)) : 1'b0);
      end
      take_result($urandom_range(0, 3));
    end

    // Reset mid-frame discards the partial sum.
    send_beat(16'h0100, 1'b0, 1'b0);
    send_beat(16'h0200, 1'b0, 1'b0);
    pulse_reset();
    send_beat(16'h0005, 1'b0, 1'b0);
    send_beat(16'h0007, 1'b0, 1'b1);
    take_result(0);

    // Reset while holding discards the result.
    send_beat(16'h0123, 1'b0, 1'b1);
    if (sb_q.size() > 0) void'(sb_q.pop_back());
    pulse_reset();
    send_beat(16'h0003, 1'b0, 1'b1);
    take_result(0);

    repeat (2) @(posedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_acc.md
MUL_ACC -- requirements
Module: mul_acc

Interface
REQ-001 Parameter n, default 8: operand width of the upstream multiplier; products are 2*n bits.
REQ-002 Parameter acc_w, default 2*n+4: accumulator width; acc_w >= 2*n+1 SHALL hold, and elaboration SHALL fail otherwise.
REQ-003 Parameter max_len, default 16: maximum number of beats per frame; max_len >= 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active-low.
REQ-006 up_valid  input  1  the upstream product beat is valid.
REQ-007 up_ready  output  1  the block accepts a beat this cycle.
REQ-008 up_prod  input  2*n  product from the signed/unsigned multiplier.
REQ-009 up_signed  input  1  up_prod is two's-complement (1) or unsigned (0).
REQ-010 up_last  input  1  this beat is the last beat of the frame.
REQ-011 down_valid  output  1  a frame result is held.
REQ-012 down_ready  input  1  the consumer accepts the result.
REQ-013 down_acc  output  acc_w  accumulated frame sum.
REQ-014 down_count  output  $clog2(max_len+1)  number of beats in the frame.
REQ-015 down_ovf  output  1  sticky flag: overflow occurred during the frame.

Function
REQ-016 A beat is accepted only when up_valid && up_ready; a result is delivered only when down_valid && down_ready.
REQ-017 The FSM SHALL have two states, ACCUM and HOLD; up_ready=1 exactly in ACCUM, down_valid=1 exactly in HOLD.
REQ-018 Each accepted beat is extended to acc_w bits: sign-extended if up_signed=1, zero-extended if 0; the extension is decided per beat.
REQ-019 The frame mode is up_signed of the frame's first beat; overflow SHALL be judged in the frame mode (signed range, or unsigned 0..2^acc_w-1).
REQ-020 Without saturation, the sum SHALL wrap modulo 2^acc_w, and down_ovf SHALL be set on any beat that overflows and held until the frame is released.
REQ-021 An accepted beat with up_last=1, or the beat that makes the count equal max_len, SHALL move the FSM ACCUM->HOLD; the result is valid on the next cycle (latency 1).
REQ-022 In HOLD, down_acc, down_count and down_ovf SHALL stay stable until the handshake, regardless of up_valid.
REQ-023 On the down handshake, the block SHALL clear the accumulator, count and ovf, and return to ACCUM; the next beat can be accepted on the following cycle (no same-cycle bypass).
REQ-024 up_prod, up_signed and up_last are don't-care when up_valid=0.

Reset
REQ-025 While rst_n=0: state=ACCUM, accumulator=0, count=0, ovf=0, down_valid=0, up_ready=0; up_ready SHALL become 1 on the first clock after deassertion.
REQ-026 Reset asserted mid-frame or in HOLD SHALL immediately discard the partial or held result.

Configuration
REQ-027 Macro MUL_ACC_SAT_EN: when defined, an overflowing sum SHALL clamp to the frame-mode limit (signed max/min, or unsigned max), and down_ovf SHALL still be set.
REQ-028 When MUL_ACC_SAT_EN is undefined, wrap-around as in REQ-020 applies and no saturation logic SHALL be present.

Structure
REQ-029 Package mul_acc_pkg SHALL hold the state enum (ACCUM, HOLD) and the helper function that computes the count width.
REQ-030 Sub-module mul_acc_add SHALL perform extension, addition, overflow detection and optional saturation combinationally; mul_acc holds the FSM and registers.

Verification
REQ-031 n=8, acc_w=20: unsigned beats 0x0010, 0x0020, 0x0030(last) -> next cycle down_acc=0x00060, count=3, ovf=0.
REQ-032 Signed beats 0xFFF0, 0x0008(last) -> down_acc=0xFFFF8 (-8), count=2.
REQ-033 max_len=4: four beats of 0x0001, none with last -> down_acc=4, count=4; a fifth up_valid waits (up_ready=0).
REQ-034 acc_w=17: unsigned 0xFFFF x3 (last on third) -> down_acc=0x0FFFD, ovf=1; with MUL_ACC_SAT_EN -> down_acc=0x1FFFF, ovf=1.
REQ-035 Hold down_ready=0 for 5 cycles in HOLD -> outputs stable and up_ready=0; on the ready cycle, the handshake occurs and the next cycle has up_ready=1 and acc=0.
REQ-036 Pulse rst_n low after 2 beats of a frame -> down_valid=0 and the next frame sums from 0.
